// File: rtl/add_1b.sv
// 1-bit full adder with combinational outputs plus registered copies.
// REG_OUT selects whether o/co come from the adder logic or from the flops.
module add_1b #(
  parameter int unsigned REG_OUT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic o,
  output logic co,
  output logic o_q,
  output logic co_q
);

  logic s;
  logic c;

  // Sum and majority carry.
  assign s = x ^ y ^ ci;
  assign c = (x & y) | (x & ci) | (y & ci);

  // Output copies load every cycle; reset clears them without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_q  <= 1'b0;
      co_q <= 1'b0;
    end else begin
      o_q  <= s;
      co_q <= c;
    end
  end

  generate
    if (REG_OUT != 0) begin : g_reg_out
      assign o  = o_q;
      assign co = co_q;
    end else begin : g_comb_out
      assign o  = s;
      assign co = c;
    end
  endgenerate

endmodule

// File: tb/tb_add_1b.sv
// Directed bench for add_1b: one instance per REG_OUT value sharing the same stimulus.
module tb_add_1b;

  logic clk;
  logic rst;
  logic x;
  logic y;
  logic ci;
  logic o0, co0, o_q0, co_q0;
  logic o1, co1, o_q1, co_q1;

  int checks = 0;
  int errors = 0;

  add_1b #(.REG_OUT(0)) u_comb (
    .clk(clk), .rst(rst), .x(x), .y(y), .ci(ci),
    .o(o0), .co(co0), .o_q(o_q0), .co_q(co_q0)
  );

  add_1b #(.REG_OUT(1)) u_reg (
    .clk(clk), .rst(rst), .x(x), .y(y), .ci(ci),
    .o(o1), .co(co1), .o_q(o_q1), .co_q(co_q1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] v);
    {x, y, ci} = v;
  endtask

  // Expected {co,o} from x+y+ci computed arithmetically.
  function automatic logic [1:0] add3(input logic [2:0] v);
    return 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
  endfunction

  logic [2:0] tbl_in  [8] = '{3'b000, 3'b100, 3'b110, 3'b111, 3'b101, 3'b001, 3'b011, 3'b010};
  logic [1:0] tbl_exp [8] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10, 2'b01, 2'b10, 2'b01};

  initial begin
    rst = 1'b1;
    drive(3'b000);
    #1;
    check("reset_q0", {co_q0, o_q0}, 2'b00);
    check("reset_q1", {co_q1, o_q1}, 2'b00);
    check("reset_out1", {co1, o1}, 2'b00);

    // Combinational table while reset is held: REG_OUT=0 ignores rst, REG_OUT=1 stays 0.
    for (int i = 0; i < 8; i++) begin
      drive(tbl_in[i]);
      #1;
      check($sformatf("comb_tbl_%0d", i), {co0, o0}, tbl_exp[i]);
      check($sformatf("reg_out_in_rst_%0d", i), {co1, o1}, 2'b00);
    end

    @(negedge clk);
    rst = 1'b0;

    // Exhaustive sweep, both variants.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      @(negedge clk);
      drive(v);
      #1;
      check($sformatf("sweep_comb_%0d", i), {co0, o0}, add3(v));
      @(posedge clk);
      #1;
      check($sformatf("sweep_reg_%0d", i), {co1, o1}, add3(v));
      check($sformatf("sweep_q_%0d", i), {co_q0, o_q0}, add3(v));
      check($sformatf("mirror_%0d", i), {co1, o1}, {co_q1, o_q1});
    end

    // Registered latency with a glitch between edges.
    @(negedge clk);
    drive(3'b000);
    @(posedge clk);
    #1;
    check("lat_pre_load", {co_q0, o_q0}, 2'b00);
    @(negedge clk);
    drive(3'b110);
    #1;
    check("lat_before_edge", {co_q0, o_q0}, 2'b00);
    check("lat_before_edge_out1", {co1, o1}, 2'b00);
    @(posedge clk);
    #1;
    check("lat_after_edge", {co_q0, o_q0}, 2'b10);
    check("lat_after_edge_out1", {co1, o1}, 2'b10);
    drive(3'b001);
    #1;
    check("glitch_comb", {co0, o0}, 2'b01);
    check("glitch_q", {co_q0, o_q0}, 2'b10);
    drive(3'b110);

    // Async reset asserted between edges.
    @(negedge clk);
    drive(3'b111);
    @(posedge clk);
    #1;
    check("pre_rst_q", {co_q0, o_q0}, 2'b11);
    check("pre_rst_out1", {co1, o1}, 2'b11);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_q0", {co_q0, o_q0}, 2'b00);
    check("async_rst_q1", {co_q1, o_q1}, 2'b00);
    check("async_rst_out1", {co1, o1}, 2'b00);
    check("async_rst_comb", {co0, o0}, 2'b11);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("rst_hold_q_%0d", i), {co_q0, o_q0}, 2'b00);
      check($sformatf("rst_hold_out1_%0d", i), {co1, o1}, 2'b00);
    end

    // Reset release loads the current inputs on the first edge.
    @(negedge clk);
    drive(3'b011);
    rst = 1'b0;
    #1;
    check("release_before_edge", {co_q0, o_q0}, 2'b00);
    @(posedge clk);
    #1;
    check("release_q", {co_q0, o_q0}, 2'b10);
    check("release_out1", {co1, o1}, 2'b10);
    check("release_mirror", {co1, o1}, {co_q1, o_q1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/add_1b.md
Name: add_1b

Overview:
- 1-bit full adder: sums operand bits x, y and carry-in ci into sum bit o and carry-out co.
- Serves as the leaf cell for ripple-carry adders and bit-serial arithmetic.
- Primary outputs are purely combinational.
- Registered copies of the outputs are also provided for pipelined or bit-serial use, on one clock with an asynchronous active-high reset.

Parameters:
- REG_OUT, default 0. 0 = o/co combinational, zero latency. 1 = o/co driven from the registered copies, 1-cycle latency.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset; clears registered outputs.
- x  input  1  operand bit A.
- y  input  1  operand bit B.
- ci  input  1  carry-in.
- o  output  1  sum bit.
- co  output  1  carry-out.
- o_q  output  1  registered sum, 1-cycle latency.
- co_q  output  1  registered carry-out, 1-cycle latency.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Arithmetic:
  - s = x XOR y XOR ci.
  - c = (x AND y) OR (x AND ci) OR (y AND ci).
  - Equivalently, {c,s} = x + y + ci as a 2-bit unsigned value (range 0..3).
- Full truth table, x y ci -> o co:
  - 000 -> 0 0
  - 001 -> 1 0
  - 010 -> 1 0
  - 011 -> 0 1
  - 100 -> 1 0
  - 101 -> 0 1
  - 110 -> 0 1
  - 111 -> 1 1
- REG_OUT=0:
  - o = s and co = c, combinational.
  - Outputs settle within the same simulation time step as any input change, with no clock dependency.
  - o and co are unaffected by rst or clk.
- Registered path, independent of REG_OUT:
  - o_q <= s and co_q <= c on every rising clk edge.
  - No enable: the registers load every cycle.
- REG_OUT=1: o = o_q and co = co_q.
- Reset:
  - While rst=1, o_q=0 and co_q=0 immediately, without waiting for a clock edge.
  - With REG_OUT=1, o and co are therefore also 0 during reset.
  - On deassertion, the first rising edge with rst=0 loads the current s/c.
  - Reset asserted mid-operation clears the registers at once; input values are irrelevant during reset.
- Inputs are sampled only at rising edges for the registered path. Input glitches between edges do not affect o_q/co_q.
- X/Z handling: no requirement beyond standard gate semantics; the bench drives only 0/1.
- No internal state other than the two output flops; no FSM.
- Power-up value of the flops before the first reset is undefined; the bench asserts rst before checking o_q/co_q.

Test Plan:
- REG_OUT=0 stimulus sequence, one row per step:
  - x/y/ci = 000 -> o=0 co=0
  - x/y/ci = 100 -> o=1 co=0
  - x/y/ci = 110 -> o=0 co=1
  - x/y/ci = 111 -> o=1 co=1
  - x/y/ci = 101 -> o=0 co=1
  - x/y/ci = 001 -> o=1 co=0
  - x/y/ci = 011 -> o=0 co=1
  - x/y/ci = 010 -> o=1 co=0
  - Check each step at the same time step as the input change.
- Exhaustive sweep: all 8 input combinations. Require {co,o} == x+y+ci for every combination, under both REG_OUT values; for REG_OUT=1, compare one cycle later.
- Registered latency: with rst=0, apply x=1, y=1, ci=0 before edge N. Then co_q=1 and o_q=0 hold after edge N, and the prior values hold before edge N.
- Async reset: with o_q=1, co_q=1 (inputs 111 clocked in), assert rst between clock edges. Then o_q=0 and co_q=0 immediately, and they stay 0 across edges while rst=1.
- Reset release: deassert rst with inputs 011. After the next rising edge, o_q=0 and co_q=1.
- REG_OUT=1 mirroring: o and co track o_q and co_q exactly, including both being 0 during reset.
